// File: rtl/demux_1to2_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to2_buf_pkg
// Brief    : Shared constants for the buffered 1-to-2 demultiplexer:
//            channel select encodings and per-channel buffer depth.
// Revision : 1.0 - initial release
// ============================================================================
package demux_1to2_buf_pkg;

    // Channel select encodings carried on select_i
    localparam logic c_SEL_CH0 = 1'b0;
    localparam logic c_SEL_CH1 = 1'b1;

    // Occupancy counter width and per-channel buffer depth
    localparam int         c_CNT_W     = 2;
    localparam logic [1:0] c_BUF_DEPTH = 2'd2;

endpackage : demux_1to2_buf_pkg
`default_nettype wire

// File: rtl/demux_1to2_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to2_buf_if
// Brief    : Producer side plus both consumer channels of the buffered
//            1-to-2 demultiplexer. Signal directions are named from the
//            point of view of the demultiplexer (slave modport).
// Revision : 1.0 - initial release
// ============================================================================
interface demux_1to2_buf_if #(
    parameter int size = 32
);
    // Producer side
    logic [size-1:0] data_i;
    logic            select_i;
    logic            valid_i;
    logic            ready_o;
    // Channel 0 consumer
    logic [size-1:0] data0_o;
    logic            valid0_o;
    logic            ready0_i;
    // Channel 1 consumer
    logic [size-1:0] data1_o;
    logic            valid1_o;
    logic            ready1_i;

    // Demultiplexer view
    modport slave (
        input  data_i, select_i, valid_i, ready0_i, ready1_i,
        output ready_o, data0_o, valid0_o, data1_o, valid1_o
    );

    // Producer / consumer (environment) view
    modport master (
        output data_i, select_i, valid_i, ready0_i, ready1_i,
        input  ready_o, data0_o, valid0_o, data1_o, valid1_o
    );
endinterface : demux_1to2_buf_if
`default_nettype wire

// File: rtl/demux_1to2_buf_buf_2entry.sv
`default_nettype none
// ============================================================================
// Module   : buf_2entry
// Brief    : Two-entry FIFO with 1-bit wrapping pointers and a 2-bit count.
//            Head word is presented combinationally from storage and reads
//            as zero while empty. Push on full / pop on empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module buf_2entry
    import demux_1to2_buf_pkg::*;
#(
    parameter int size = 32
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    input  wire logic [size-1:0] data_i,
    input  wire logic            push_i,
    input  wire logic            pop_i,
    output logic      [size-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [size-1:0]    mem_q [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               w_push;
    logic               w_pop;

    assign full_o  = (count_q == c_BUF_DEPTH);
    assign empty_o = (count_q == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointer/count: a simultaneous push and pop leaves the count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + 2'd1;
        end else if (w_pop && !w_push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage and pointer registers; reset empties the buffer at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : buf_2entry
`default_nettype wire

// File: rtl/demux_1to2_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to2_buf
// Brief    : Registered 1-to-2 demultiplexer. Each accepted word is steered
//            by select_i into one of two independent 2-entry buffers, so a
//            stalled consumer never blocks the other channel.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1to2_buf
    import demux_1to2_buf_pkg::*;
#(
    parameter int size = 32
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    demux_1to2_buf_if.slave   bus
);

    logic            w_full0, w_full1;
    logic            w_empty0, w_empty1;
    logic            w_accept;
    logic            w_push0, w_push1;
    logic            w_pop0, w_pop1;
    logic [size-1:0] w_data0, w_data1;

    // ready_o depends only on select_i and the registered fill levels,
    // never on the consumer ready inputs
    assign bus.ready_o = (bus.select_i == c_SEL_CH1) ? !w_full1 : !w_full0;
    assign w_accept    = bus.valid_i && bus.ready_o;
    assign w_push0     = w_accept && (bus.select_i == c_SEL_CH0);
    assign w_push1     = w_accept && (bus.select_i == c_SEL_CH1);

    assign bus.valid0_o = !w_empty0;
    assign bus.valid1_o = !w_empty1;
    assign w_pop0       = bus.valid0_o && bus.ready0_i;
    assign w_pop1       = bus.valid1_o && bus.ready1_i;
    assign bus.data0_o  = w_data0;
    assign bus.data1_o  = w_data1;

    buf_2entry #(.size(size)) u_buf0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (bus.data_i),
        .push_i  (w_push0),
        .pop_i   (w_pop0),
        .data_o  (w_data0),
        .full_o  (w_full0),
        .empty_o (w_empty0)
    );

    buf_2entry #(.size(size)) u_buf1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (bus.data_i),
        .push_i  (w_push1),
        .pop_i   (w_pop1),
        .data_o  (w_data1),
        .full_o  (w_full1),
        .empty_o (w_empty1)
    );

endmodule : demux_1to2_buf
`default_nettype wire

// File: tb/tb_demux_1to2_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1to2_buf
// Brief    : Self-checking bench for demux_1to2_buf: a vector table for the
//            basic steering/backpressure/push-pop cases, hand sequences for
//            streaming, isolation and asynchronous reset, and a per-channel
//            queue scoreboard watching every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1to2_buf;

    localparam int c_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    demux_1to2_buf_if #(.size(c_W)) bus ();

    demux_1to2_buf #(.size(c_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [c_W-1:0] act, input logic [c_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [c_W-1:0] q0[$];
    logic [c_W-1:0] q1[$];
    int n_push1 = 0;
    int n_pop1  = 0;
    int max_q1  = 0;

    // Sample mid-cycle: compare outputs with the queue model, then apply
    // the transfers the coming rising edge will perform.
    always @(negedge clk) begin
        logic           e_rdy, e_v0, e_v1;
        logic [c_W-1:0] tmp;
        if (rst) begin
            q0.delete();
            q1.delete();
        end
        e_v0  = (q0.size() != 0);
        e_v1  = (q1.size() != 0);
        e_rdy = bus.select_i ? (q1.size() != 2) : (q0.size() != 2);
        chk("sb ready_o", c_W'(bus.ready_o), c_W'(e_rdy));
        chk("sb valid0_o", c_W'(bus.valid0_o), c_W'(e_v0));
        chk("sb valid1_o", c_W'(bus.valid1_o), c_W'(e_v1));
        chk("sb data0_o", bus.data0_o, e_v0 ? q0[0] : '0);
        chk("sb data1_o", bus.data1_o, e_v1 ? q1[0] : '0);
        if (!rst) begin
            if (e_v0 && bus.ready0_i) tmp = q0.pop_front();
            if (e_v1 && bus.ready1_i) begin
                tmp = q1.pop_front();
                n_pop1++;
            end
            if (bus.valid_i && e_rdy) begin
                if (bus.select_i) begin
                    q1.push_back(bus.data_i);
                    n_push1++;
                end else begin
                    q0.push_back(bus.data_i);
                end
            end
            if (q1.size() > max_q1) max_q1 = q1.size();
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic           sel;
        logic [c_W-1:0] data;
        logic           valid;
        logic           r0;
        logic           r1;
        logic           e_ready;
        logic           e_v0;
        logic [c_W-1:0] e_d0;
        logic           e_v1;
        logic [c_W-1:0] e_d1;
    } vec_t;

    vec_t vecs[12];

    task automatic drive(input logic sel, input logic [c_W-1:0] d, input logic v,
                         input logic r0, input logic r1);
        bus.select_i = sel;
        bus.data_i   = d;
        bus.valid_i  = v;
        bus.ready0_i = r0;
        bus.ready1_i = r1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p_start, pop_start;

        //          sel   data   v     r0    r1    rdy   v0    d0     v1    d1
        vecs[0]  = '{1'b0, 32'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 1'b1, 32'h22};
        vecs[2]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1,  1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1,  1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1,  1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1,  1'b1, 32'h3};
        vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2,  1'b1, 32'h3};
        vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7,  1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h8,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8,  1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};

        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset valid0_o", c_W'(bus.valid0_o), '0);
        chk("reset valid1_o", c_W'(bus.valid1_o), '0);
        chk("reset ready_o", c_W'(bus.ready_o), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].sel, vecs[i].data, vecs[i].valid, vecs[i].r0, vecs[i].r1);
            step();
            chk($sformatf("vec%0d ready_o", i), c_W'(bus.ready_o), c_W'(vecs[i].e_ready));
            chk($sformatf("vec%0d valid0_o", i), c_W'(bus.valid0_o), c_W'(vecs[i].e_v0));
            chk($sformatf("vec%0d data0_o", i), bus.data0_o, vecs[i].e_d0);
            chk($sformatf("vec%0d valid1_o", i), c_W'(bus.valid1_o), c_W'(vecs[i].e_v1));
            chk($sformatf("vec%0d data1_o", i), bus.data1_o, vecs[i].e_d1);
        end

        // Streaming: 16 words into channel 1 with its consumer always ready
        p_start   = n_push1;
        pop_start = n_pop1;
        max_q1    = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, c_W'(i), 1'b1, 1'b0, 1'b1);
            step();
            chk("stream data1_o", bus.data1_o, c_W'(i));
            chk("stream valid1_o", c_W'(bus.valid1_o), 32'd1);
        end
        drive(1'b1, '0, 1'b0, 1'b0, 1'b1);
        chk("stream accepts", c_W'(n_push1 - p_start), 32'd16);
        step();
        step();
        chk("stream pops", c_W'(n_pop1 - pop_start), 32'd16);
        chk("stream max count1", c_W'(max_q1), 32'd1);

        // Isolation: channel 0 full and stalled while channel 1 streams
        drive(1'b0, 32'hC0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'hC1, 1'b1, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h100 + c_W'(i), 1'b1, 1'b0, 1'b1);
            step();
            chk("iso data1_o", bus.data1_o, 32'h100 + c_W'(i));
            chk("iso data0_o", bus.data0_o, 32'hC0);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        chk("iso ch0 full ready_o", c_W'(bus.ready_o), '0);
        chk("iso ch1 drained", c_W'(bus.valid1_o), '0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step();
        chk("iso drain data0_o", bus.data0_o, 32'hC1);
        step();
        chk("iso drained valid0_o", c_W'(bus.valid0_o), '0);

        // Asynchronous reset with both channels full
        drive(1'b0, 32'hD0, 1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 32'hD1, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 32'hE0, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 32'hE1, 1'b1, 1'b0, 1'b0); step();
        chk("pre-rst ready_o", c_W'(bus.ready_o), '0);
        drive(1'b1, 32'hE2, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst valid0_o", c_W'(bus.valid0_o), '0);
        chk("async rst valid1_o", c_W'(bus.valid1_o), '0);
        chk("async rst data0_o", bus.data0_o, '0);
        chk("async rst data1_o", bus.data1_o, '0);
        chk("async rst ready_o", c_W'(bus.ready_o), 32'd1);
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
        step();
        chk("post-rst data0_o", bus.data0_o, 32'hA5A5_0001);
        chk("post-rst valid0_o", c_W'(bus.valid0_o), 32'd1);
        chk("post-rst valid1_o", c_W'(bus.valid1_o), '0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_demux_1to2_buf
`default_nettype wire
